// File: rtl/ptl_link_scheduler.sv
// Round-robin scheduler sharing one PTL driver among N_REQ channels.
// Define PTL_PRIO0_EN to give channel 0 strict priority over the others.
module ptl_link_scheduler #(
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 3,
    parameter int GUARD_CYC = 2,
    parameter int SEL_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] full,
    output logic             q,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             drop_err
);

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [GW-1:0] GLOAD =
        GW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        GUARD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt [N_REQ];
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_win;
    logic [SEL_W-1:0] r_sel;
    logic [GW-1:0]    r_gcnt;
    logic             r_q;
    logic             r_drop;

    logic [N_REQ-1:0] w_nz;
    logic [N_REQ-1:0] w_dec;
    logic [N_REQ-1:0] w_drop;
    logic [SEL_W-1:0] w_pick;
    logic             w_any;
    logic             w_found;
    int               w_idx;

    always_comb begin
        w_nz   = '0;
        full   = '0;
        w_dec  = '0;
        w_drop = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_nz[i]   = (r_cnt[i] != '0);
            full[i]   = (r_cnt[i] == CNT_MAX);
            w_dec[i]  = (r_state == FIRE) && (r_win == SEL_W'(i));
            w_drop[i] = req[i] && !w_dec[i] && full[i];
        end
    end

    // First non-empty channel at or above ptr, wrapping around.
    always_comb begin
        w_any   = |w_nz;
        w_pick  = '0;
        w_found = 1'b0;
        w_idx   = 0;
`ifdef PTL_PRIO0_EN
        if (w_nz[0]) begin
            w_found = 1'b1;
        end
`endif
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_found && w_nz[w_idx]) begin
                w_found = 1'b1;
                w_pick  = SEL_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_state_nxt = FIRE;
            FIRE:    w_state_nxt = (GUARD_CYC > 0) ? GUARD : IDLE;
            GUARD:   if (r_gcnt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_sel   <= '0;
            r_gcnt  <= '0;
            r_q     <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any) begin
                r_win <= w_pick;
            end
            if (r_state == FIRE) begin
                r_q    <= ~r_q;
                r_sel  <= r_win;
                r_ptr  <= (r_win == LAST) ? '0 : r_win + 1'b1;
                r_gcnt <= GLOAD;
            end else if (r_state == GUARD && r_gcnt != '0) begin
                r_gcnt <= r_gcnt - 1'b1;
            end
            if (|w_drop) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Same-edge request and launch cancel out, even when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && !w_dec[i] && !full[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (!req[i] && w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign q        = r_q;
    assign sel      = r_sel;
    assign busy     = (r_state != IDLE);
    assign drop_err = r_drop;

endmodule

// File: doc/ptl_link_scheduler.md
Name: ptl_link_scheduler

Overview:
- Clocked scheduler that shares one passive-transmission-line (PTL) driver/receiver pair among N_REQ requester channels.
- Queues pulse requests per channel and grants the link round-robin.
- Launches one pulse per grant as an edge-encoded transition on q (every edge of q is one SFQ pulse, the same convention the PTL receiver models use).
- Enforces a minimum inter-pulse spacing so the downstream receiver's critical-timing window is never violated.

Parameters:
- N_REQ, 4, number of requester channels (2..16)
- CNT_W, 3, width of each channel's pending-pulse counter; saturates at 2^CNT_W-1
- GUARD_CYC, 2, idle cycles enforced after each launch (0 allowed)
- SEL_W, $clog2(N_REQ), width of sel

Ports:
- clk  input  1  clock, rising edge active
- rst  input  1  asynchronous reset, active-high
- req  input  N_REQ  per-channel pulse request; each bit high at a rising edge = one pulse queued
- full  output  N_REQ  per-channel counter at maximum (combinational from counter)
- q  output  1  edge-encoded PTL drive; toggles once per launched pulse
- sel  output  SEL_W  channel index of the most recent launch
- busy  output  1  high whenever state != IDLE
- drop_err  output  1  sticky; set when a request is discarded

Behaviour:
- Reset: asynchronous and active-high. Clears counters, ptr and the guard counter. q=0, sel=0, busy=0, drop_err=0, state=IDLE.
- Reset mid-operation aborts any FIRE/GUARD state; queued pulses are lost; no toggle follows.
- Counters:
  - req[i] sampled at edge E increments cnt[i] at E.
  - If cnt[i] is decremented at the same edge (launch from channel i), the net change is 0 and the request is accepted.
  - If cnt[i]==max and there is no same-edge decrement, the request is dropped and drop_err<=1 (cleared only by rst).
- FSM states IDLE, FIRE, GUARD:
  - IDLE: if any cnt!=0, pick the winner by searching from ptr upward with wrap-around. Latch win, go to FIRE. Otherwise stay in IDLE.
  - FIRE (1 cycle): at exit edge, q<=~q, sel<=win, cnt[win]-=1, ptr<=(win+1) mod N_REQ. Next state is GUARD if GUARD_CYC>0, else IDLE.
  - GUARD: stays exactly GUARD_CYC cycles, then IDLE. Requests still queue during GUARD.
- Latency: req at edge E with the link idle -> q toggles at edge E+2.
- Back-to-back launches are spaced GUARD_CYC+2 cycles apart.
- Winner is fixed once FIRE is entered. Requests arriving while in FIRE do not change win.
- The ptr update uses the winner, not the requester set.

Optional Feature:
- Macro PTL_PRIO0_EN.
- Defined: channel 0 has strict priority. In IDLE, if cnt[0]!=0, win=0 regardless of ptr. Otherwise round-robin over the remaining channels from ptr. ptr still advances to win+1.
- Undefined: pure round-robin over all channels.

Test Plan (N_REQ=4, CNT_W=3, GUARD_CYC=2, reset released before edge 5):
- Single req[2] at edge 10 -> q 0->1 at edge 12, sel=2. busy=1 after edges 11..13, busy=0 after edge 14.
- req=4'b1111 at edge 10 -> q toggles at edges 12,16,20,24; sel sequence 0,1,2,3; q=0 after edge 24.
- req[1] held high edges 10..21 -> launches at 12,16,20; full[1]=1 after edge 18; drop_err=1 after edge 19; cnt[1] never exceeds 7.
- Traffic as in the 4'b1111 case, rst pulsed high between edges 13 and 14 -> q, sel, busy, full return to 0 immediately; no toggles after rst release with req=0.
- req[0]&req[3] at edge 10, req[0] again at edge 13:
  - without PTL_PRIO0_EN -> launches sel 0 @12, 3 @16, 0 @20
  - with PTL_PRIO0_EN -> sel 0 @12, 0 @16, 3 @20
